// File: rtl/zbus_decode.sv
// Z80 bus-cycle decoder: synchronizes the raw bus, classifies each completed
// cycle and queues {type, addr, data} records for a valid/ready consumer.
module zbus_decode #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned MIN_LOW     = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] z_a,
  input  logic [7:0]  z_d,
  input  logic        z_mreq_n,
  input  logic        z_iorq_n,
  input  logic        z_rd_n,
  input  logic        z_wr_n,
  input  logic        z_m1_n,
  input  logic        z_rfsh_n,
  output logic        cyc_valid,
  input  logic        cyc_ready,
  output logic [2:0]  cyc_type,
  output logic [15:0] cyc_addr,
  output logic [7:0]  cyc_data,
  output logic        ovf,
  input  logic        clr_ovf
);

  localparam int unsigned SW   = 16 + 8 + 6;
  localparam int unsigned PW   = $clog2(FIFO_DEPTH);
  localparam int unsigned PTRW = PW + 1;
  localparam int unsigned QW   = $clog2(MIN_LOW + 1);
  localparam int unsigned KW   = $clog2(SYNC_STAGES + 1);
  localparam logic [SW-1:0] SYNC_IDLE = SW'(30'h0000_003f);

  localparam logic [2:0] S_SKIP   = 3'd0;
  localparam logic [2:0] S_IDLE   = 3'd1;
  localparam logic [2:0] S_QUAL   = 3'd2;
  localparam logic [2:0] S_ACTIVE = 3'd3;
  localparam logic [2:0] S_PUSH   = 3'd4;

  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
  } rec_t;

  // Input synchronizer, one aligned chain for every Z80 pin
  logic [SW-1:0] sync_q [SYNC_STAGES];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) sync_q[i] <= SYNC_IDLE;
    end else begin
      sync_q[0] <= {z_a, z_d, z_mreq_n, z_iorq_n, z_rd_n, z_wr_n, z_m1_n, z_rfsh_n};
      for (int i = 1; i < int'(SYNC_STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  logic [15:0] a_s;
  logic [7:0]  d_s;
  logic        mreq_n_s, iorq_n_s, rd_n_s, wr_n_s, m1_n_s, rfsh_n_s;

  assign {a_s, d_s, mreq_n_s, iorq_n_s, rd_n_s, wr_n_s, m1_n_s, rfsh_n_s} = sync_q[SYNC_STAGES-1];

  // Per-type condition vector (indexed by type code) and priority classification
  logic [7:0] cond;
  logic [2:0] cls;
  logic       act;
  logic       refresh;

  always_comb begin
    cond    = '0;
    cond[0] = ~mreq_n_s & ~rd_n_s;
    cond[1] = ~mreq_n_s & ~wr_n_s;
    cond[2] = ~iorq_n_s & ~rd_n_s;
    cond[3] = ~iorq_n_s & ~wr_n_s;
    cond[4] = ~m1_n_s & ~mreq_n_s & ~rd_n_s;
    cond[5] = ~m1_n_s & ~iorq_n_s;
    refresh = ~mreq_n_s & ~rfsh_n_s & rd_n_s & wr_n_s;
    act     = (|cond) & ~refresh;
    cls     = 3'd0;
    if      (cond[5]) cls = 3'd5;
    else if (cond[4]) cls = 3'd4;
    else if (cond[0]) cls = 3'd0;
    else if (cond[1]) cls = 3'd1;
    else if (cond[2]) cls = 3'd2;
    else if (cond[3]) cls = 3'd3;
  end

  logic [2:0]    state_q, state_d;
  logic [2:0]    type_q;
  logic [15:0]   addr_q;
  logic [7:0]    data_q;
  logic [QW-1:0] qual_cnt_q;
  logic [KW-1:0] skip_cnt_q;
  logic          skip_done;
  logic          latch_start, qual_inc, load_data, push;

  // SKIP also waits until the reset-preloaded synchronizer has filled with real samples
  assign skip_done = (skip_cnt_q == KW'(SYNC_STAGES));

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_SKIP;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    latch_start = 1'b0;
    qual_inc    = 1'b0;
    load_data   = 1'b0;
    push        = 1'b0;
    case (state_q)
      S_SKIP: begin
        if (skip_done && !act) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (act) begin
          latch_start = 1'b1;
          load_data   = 1'b1;
          state_d     = (MIN_LOW <= 1) ? S_ACTIVE : S_QUAL;
        end
      end
      S_QUAL: begin
        if (act && (cls == type_q)) begin
          qual_inc  = 1'b1;
          load_data = 1'b1;
          if (qual_cnt_q == QW'(MIN_LOW - 1)) state_d = S_ACTIVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ACTIVE: begin
        if (cond[type_q]) load_data = 1'b1;
        else              state_d   = S_PUSH;
      end
      S_PUSH: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_SKIP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      type_q     <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      qual_cnt_q <= '0;
      skip_cnt_q <= '0;
    end else begin
      if (latch_start) begin
        type_q     <= cls;
        addr_q     <= a_s;
        qual_cnt_q <= QW'(1);
      end
      if (qual_inc)   qual_cnt_q <= qual_cnt_q + QW'(1);
      if (load_data)  data_q     <= d_s;
      if (!skip_done) skip_cnt_q <= skip_cnt_q + KW'(1);
    end
  end

  // Record FIFO with an extra pointer bit to separate full from empty
  rec_t            mem_q [FIFO_DEPTH];
  logic [PTRW-1:0] wptr_q, rptr_q;
  logic            empty, full, pop, wr_en, ovf_set;
  rec_t            head;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[PW] != rptr_q[PW]) && (wptr_q[PW-1:0] == rptr_q[PW-1:0]);
  assign cyc_valid = ~empty;
  assign pop       = cyc_valid & cyc_ready;
  assign wr_en     = push & (~full | pop);
  assign ovf_set   = push & full & ~pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(FIFO_DEPTH); i++) mem_q[i] <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      ovf    <= 1'b0;
    end else begin
      if (wr_en) begin
        mem_q[wptr_q[PW-1:0]] <= '{typ: type_q, addr: addr_q, data: data_q};
        wptr_q                <= wptr_q + PTRW'(1);
      end
      if (pop) rptr_q <= rptr_q + PTRW'(1);
      if (ovf_set)      ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
    end
  end

  assign head     = mem_q[rptr_q[PW-1:0]];
  assign cyc_type = head.typ;
  assign cyc_addr = head.addr;
  assign cyc_data = head.data;

endmodule

// File: tb/tb_zbus_decode.sv
// Bench for zbus_decode: directed vector table, hand-written corner sequences
// and random bus cycles checked against a record-queue reference model.
module tb_zbus_decode;

  localparam int unsigned SYNC  = 2;
  localparam int unsigned MINL  = 2;
  localparam int unsigned DEPTH = 4;

  localparam int K_MRD  = 0;
  localparam int K_MWR  = 1;
  localparam int K_IORD = 2;
  localparam int K_IOWR = 3;
  localparam int K_M1   = 4;
  localparam int K_INTA = 5;
  localparam int K_RFSH = 6;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] z_a;
  logic [7:0]  z_d;
  logic        z_mreq_n, z_iorq_n, z_rd_n, z_wr_n, z_m1_n, z_rfsh_n;
  logic        cyc_valid, cyc_ready;
  logic [2:0]  cyc_type;
  logic [15:0] cyc_addr;
  logic [7:0]  cyc_data;
  logic        ovf, clr_ovf;

  zbus_decode #(.SYNC_STAGES(SYNC), .MIN_LOW(MINL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .z_a(z_a), .z_d(z_d),
    .z_mreq_n(z_mreq_n), .z_iorq_n(z_iorq_n), .z_rd_n(z_rd_n), .z_wr_n(z_wr_n),
    .z_m1_n(z_m1_n), .z_rfsh_n(z_rfsh_n),
    .cyc_valid(cyc_valid), .cyc_ready(cyc_ready), .cyc_type(cyc_type),
    .cyc_addr(cyc_addr), .cyc_data(cyc_data), .ovf(ovf), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  typ;
    logic [15:0] addr;
    logic [7:0]  data;
  } rec_t;

  typedef struct {
    int          kind;
    logic [15:0] a;
    logic [7:0]  d;
    int          w;
    bit          exp_v;
    logic [2:0]  exp_t;
  } vec_t;

  int   errors = 0;
  int   checks = 0;
  bit   mon_en = 1'b0;
  bit   rand_en = 1'b0;
  rec_t exp_q[$];
  vec_t vt[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Record type a bus cycle of the given kind should produce
  function automatic logic [2:0] kind_type(input int k);
    case (k)
      K_MRD:   return 3'd0;
      K_MWR:   return 3'd1;
      K_IORD:  return 3'd2;
      K_IOWR:  return 3'd3;
      K_M1:    return 3'd4;
      default: return 3'd5;
    endcase
  endfunction

  // One clock: monitor accepted records at the negedge, drive at posedge+1
  task automatic tick();
    @(negedge clk);
    if (mon_en && cyc_valid && cyc_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_record", {cyc_type, cyc_addr, cyc_data}, 32'hffff_ffff);
      end else begin
        rec_t e;
        e = exp_q.pop_front();
        check("rand_record", {5'd0, cyc_type, cyc_addr, cyc_data}, {5'd0, e});
      end
    end
    @(posedge clk);
    #1;
    if (rand_en) cyc_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic release_all();
    z_mreq_n = 1'b1; z_iorq_n = 1'b1; z_rd_n = 1'b1;
    z_wr_n   = 1'b1; z_m1_n   = 1'b1; z_rfsh_n = 1'b1;
  endtask

  task automatic set_strobes(input int k);
    release_all();
    case (k)
      K_MRD:   begin z_mreq_n = 1'b0; z_rd_n = 1'b0; end
      K_MWR:   begin z_mreq_n = 1'b0; z_wr_n = 1'b0; end
      K_IORD:  begin z_iorq_n = 1'b0; z_rd_n = 1'b0; end
      K_IOWR:  begin z_iorq_n = 1'b0; z_wr_n = 1'b0; end
      K_M1:    begin z_m1_n = 1'b0; z_mreq_n = 1'b0; z_rd_n = 1'b0; end
      K_INTA:  begin z_m1_n = 1'b0; z_iorq_n = 1'b0; end
      default: begin z_mreq_n = 1'b0; z_rfsh_n = 1'b0; end
    endcase
  endtask

  task automatic bus_cycle(input int k, input logic [15:0] a, input logic [7:0] d,
                           input int w, input int gap);
    z_a = a;
    z_d = d;
    set_strobes(k);
    repeat (w) tick();
    release_all();
    repeat (gap) tick();
  endtask

  task automatic pop_head();
    cyc_ready = 1'b1;
    tick();
    cyc_ready = 1'b0;
  endtask

  task automatic check_head(input string name, input logic [2:0] t, input logic [15:0] a,
                            input logic [7:0] d);
    check({name, "_valid"}, cyc_valid, 1);
    check({name, "_rec"}, {cyc_type, cyc_addr, cyc_data}, {t, a, d});
  endtask

  initial begin
    rst = 1'b1; clr_ovf = 1'b0; cyc_ready = 1'b0; z_a = '0; z_d = '0;
    release_all();

    vt[0] = '{K_MRD,  16'h1234, 8'hA5, 8, 1'b1, 3'd0};
    vt[1] = '{K_M1,   16'h0040, 8'h3E, 4, 1'b1, 3'd4};
    vt[2] = '{K_RFSH, 16'h0012, 8'h00, 3, 1'b0, 3'd0};
    vt[3] = '{K_IOWR, 16'h00FE, 8'h07, 4, 1'b1, 3'd3};
    vt[4] = '{K_INTA, 16'h0038, 8'hFF, 4, 1'b1, 3'd5};
    vt[5] = '{K_MRD,  16'h2222, 8'h33, 1, 1'b0, 3'd0};
    vt[6] = '{K_IORD, 16'h00FE, 8'h5A, 2, 1'b1, 3'd2};
    vt[7] = '{K_MWR,  16'hFFFF, 8'h00, 3, 1'b1, 3'd1};

    repeat (3) tick();
    rst = 1'b0;
    check("reset_valid", cyc_valid, 0);
    check("reset_type", cyc_type, 0);
    check("reset_addr", cyc_addr, 0);
    check("reset_data", cyc_data, 0);
    check("reset_ovf", ovf, 0);
    repeat (4) tick();

    // Directed vectors: exact push latency after strobe release, then head contents
    for (int i = 0; i < 8; i++) begin
      z_a = vt[i].a;
      z_d = vt[i].d;
      set_strobes(vt[i].kind);
      repeat (vt[i].w) tick();
      release_all();
      repeat (SYNC + 1) tick();
      check($sformatf("vec%0d_early_valid", i), cyc_valid, 0);
      tick();
      check($sformatf("vec%0d_valid", i), cyc_valid, 32'(vt[i].exp_v));
      if (vt[i].exp_v) begin
        check_head($sformatf("vec%0d", i), vt[i].exp_t, vt[i].a, vt[i].d);
        pop_head();
        check($sformatf("vec%0d_drained", i), cyc_valid, 0);
      end
      check($sformatf("vec%0d_ovf", i), ovf, 0);
      repeat (3) tick();
    end

    // Two queued records keep their order
    bus_cycle(K_IOWR, 16'h00FE, 8'h07, 4, 3);
    bus_cycle(K_INTA, 16'h0038, 8'hFF, 4, 6);
    check_head("order0", 3'd3, 16'h00FE, 8'h07);
    pop_head();
    check_head("order1", 3'd5, 16'h0038, 8'hFF);
    pop_head();
    check("order_empty", cyc_valid, 0);

    // Overflow: five writes into a four-deep FIFO with no consumer
    for (int i = 0; i < 5; i++) bus_cycle(K_MWR, 16'h8000 + 16'(i), 8'(i), 3, 3);
    repeat (6) tick();
    check("ovf_set", ovf, 1);
    clr_ovf = 1'b1;
    tick();
    clr_ovf = 1'b0;
    check("ovf_clear", ovf, 0);
    for (int i = 0; i < 4; i++) begin
      check_head($sformatf("ovf_rec%0d", i), 3'd1, 16'h8000 + 16'(i), 8'(i));
      pop_head();
    end
    check("ovf_drained", cyc_valid, 0);

    // Refill to full, then pop in the same cycle as the fifth push
    for (int i = 0; i < 4; i++) bus_cycle(K_MWR, 16'h9000 + 16'(i), 8'h40 + 8'(i), 3, 3);
    repeat (4) tick();
    check("refill_ovf", ovf, 0);
    z_a = 16'h9004;
    z_d = 8'h44;
    set_strobes(K_MWR);
    repeat (3) tick();
    release_all();
    repeat (3) tick();
    cyc_ready = 1'b1;
    tick();
    cyc_ready = 1'b0;
    repeat (2) tick();
    check("simul_ovf", ovf, 0);
    for (int i = 1; i < 5; i++) begin
      check_head($sformatf("simul_rec%0d", i), 3'd1, 16'h9000 + 16'(i), 8'h40 + 8'(i));
      pop_head();
    end
    check("simul_drained", cyc_valid, 0);

    // Reset in the middle of an active read, strobe held across reset release
    z_a = 16'h4000;
    z_d = 8'h11;
    set_strobes(K_MRD);
    repeat (5) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    check("midrst_valid0", cyc_valid, 0);
    repeat (8) tick();
    check("midrst_held", cyc_valid, 0);
    release_all();
    repeat (8) tick();
    check("midrst_release", cyc_valid, 0);
    check("midrst_ovf", ovf, 0);
    bus_cycle(K_MRD, 16'h4321, 8'h99, 4, 6);
    check_head("midrst_next", 3'd0, 16'h4321, 8'h99);
    pop_head();
    check("midrst_drained", cyc_valid, 0);

    // Random bus cycles against the record-queue model
    mon_en  = 1'b1;
    rand_en = 1'b1;
    for (int n = 0; n < 40; n++) begin
      int          k, w, g;
      logic [15:0] a;
      logic [7:0]  d;
      rec_t        r;
      k = $urandom_range(0, 6);
      a = 16'($urandom);
      d = 8'($urandom);
      w = $urandom_range(1, 6);
      g = $urandom_range(2, 5);
      if (k != K_RFSH && w >= int'(MINL)) begin
        r.typ  = kind_type(k);
        r.addr = a;
        r.data = d;
        exp_q.push_back(r);
      end
      bus_cycle(k, a, d, w, g);
    end
    rand_en   = 1'b0;
    cyc_ready = 1'b1;
    repeat (20) tick();
    check("rand_leftover", 32'(exp_q.size()), 0);
    check("rand_ovf", ovf, 0);
    check("rand_empty", cyc_valid, 0);
    mon_en    = 1'b0;
    cyc_ready = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
